// File: rtl/lc2k_program_loader.sv
// Boot loader for the LC2K core: turns a byte stream (16-bit big-endian length
// header, then big-endian words) into memory writes, then releases the core.
module lc2k_program_loader #(
  parameter int MEM_DEPTH  = 65536,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  cpu_halt_i,
  output logic                  cpu_run_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           word_count_o
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, WORD, RUN, DONE, ERR} state_e;

  state_e                state_q, state_d;
  logic                  in_ready_q, busy_q, done_q, error_q, cpu_run_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [15:0]           word_count_q;
  logic [23:0]           shift_q;
  logic [1:0]            byte_cnt_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;

  logic        accept;
  logic [15:0] hdr_n;
  logic        last_word;

  assign accept    = in_valid_i && in_ready_q;
  assign hdr_n     = {word_count_q[15:8], in_data_i};
  assign last_word = (byte_cnt_q == 2'd3) &&
                     ((32'(word_cnt_q) + 32'd1) == 32'(word_count_q));

  // The core is only allowed to see halt once it has actually been released.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (start_i) state_d = HDR0;
      HDR0:            if (accept) state_d = HDR1;
      HDR1: if (accept) begin
        if (32'(hdr_n) > 32'(MEM_DEPTH)) state_d = ERR;
        else if (hdr_n == 16'd0)         state_d = RUN;
        else                             state_d = WORD;
      end
      WORD:    if (accept && last_word) state_d = RUN;
      RUN:     if (cpu_halt_i && cpu_run_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_run_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      word_count_q <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == HDR0) || (state_d == HDR1) || (state_d == WORD);
      busy_q     <= (state_d == HDR0) || (state_d == HDR1) || (state_d == WORD);
      done_q     <= (state_d == DONE);
      error_q    <= (state_d == ERR);
      // Entering RUN from WORD leaves one cycle for the trailing write first.
      cpu_run_q  <= (state_d == RUN) && (state_q != WORD);
      mem_we_q   <= 1'b0;
      if ((state_q == IDLE || state_q == DONE || state_q == ERR) && start_i) begin
        byte_cnt_q <= '0;
        word_cnt_q <= '0;
      end
      if (accept) begin
        unique case (state_q)
          HDR0: word_count_q[15:8] <= in_data_i;
          HDR1: word_count_q[7:0]  <= in_data_i;
          WORD: begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
              mem_wdata_q <= {shift_q, in_data_i};
              word_cnt_q  <= word_cnt_q + 1'b1;
            end else begin
              shift_q <= {shift_q[15:0], in_data_i};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready_o   = in_ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign cpu_run_o    = cpu_run_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_lc2k_program_loader.sv
// Directed bench for lc2k_program_loader: table of images plus halt/restart and
// mid-load reset sequences, with a write monitor collecting every mem_we.
module tb_lc2k_program_loader;
  localparam int MEM_DEPTH = 4;
  localparam int AW        = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          cpu_halt = 1'b0;
  logic          in_ready, mem_we, cpu_run, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [15:0]   word_count;

  int tests = 0;
  int fails = 0;

  lc2k_program_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .cpu_halt_i(cpu_halt),
    .cpu_run_o(cpu_run), .busy_o(busy), .done_o(done), .error_o(error),
    .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk) if (mem_we === 1'b1) wq.push_back('{mem_addr, mem_wdata});

  typedef struct {
    string       name;
    int          n;
    logic [31:0] w[4];
    bit          gap;
    bit          exp_err;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/in_ready"}, in_ready, 0);
    chk({tag, "/mem_we"}, mem_we, 0);
    chk({tag, "/cpu_run"}, cpu_run, 0);
    chk({tag, "/busy"}, busy, 0);
    chk({tag, "/done"}, done, 0);
    chk({tag, "/error"}, error, 0);
    chk({tag, "/mem_addr"}, mem_addr, 0);
    chk({tag, "/mem_wdata"}, mem_wdata, 0);
    chk({tag, "/word_count"}, word_count, 0);
  endtask

  task automatic run_load(input vec_t v);
    logic [7:0] bs[$];
    int nw;
    nw = v.exp_err ? 0 : v.n;
    bs.push_back(8'(v.n >> 8));
    bs.push_back(8'(v.n));
    for (int i = 0; i < nw; i++) begin
      bs.push_back(v.w[i][31:24]);
      bs.push_back(v.w[i][23:16]);
      bs.push_back(v.w[i][15:8]);
      bs.push_back(v.w[i][7:0]);
    end
    @(negedge clk);
    wq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, "/busy_after_start"}, busy, 1);
    chk({v.name, "/in_ready_after_start"}, in_ready, 1);
    chk({v.name, "/error_cleared"}, error, 0);
    chk({v.name, "/done_cleared"}, done, 0);
    for (int i = 0; i < bs.size(); i++) begin
      in_valid = 1'b1;
      in_data  = bs[i];
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'hFF;
      if (v.gap && i != bs.size() - 1) @(negedge clk);
    end
    if (v.exp_err) begin
      chk({v.name, "/error"}, error, 1);
      chk({v.name, "/in_ready_err"}, in_ready, 0);
      chk({v.name, "/cpu_run_err"}, cpu_run, 0);
    end else if (nw == 0) begin
      chk({v.name, "/cpu_run_immediate"}, cpu_run, 1);
      chk({v.name, "/mem_we_none"}, mem_we, 0);
    end else begin
      chk({v.name, "/last_we"}, mem_we, 1);
      chk({v.name, "/cpu_run_not_with_we"}, cpu_run, 0);
      chk({v.name, "/last_addr"}, mem_addr, 32'(nw - 1));
      @(negedge clk);
      chk({v.name, "/we_single_cycle"}, mem_we, 0);
      chk({v.name, "/cpu_run_after_we"}, cpu_run, 1);
    end
    @(negedge clk);
    chk({v.name, "/busy_end"}, busy, 0);
    chk({v.name, "/in_ready_end"}, in_ready, 0);
    chk({v.name, "/word_count"}, word_count, 32'(v.n));
    chk({v.name, "/write_count"}, wq.size(), nw);
    for (int i = 0; i < wq.size() && i < nw; i++) begin
      chk($sformatf("%s/addr%0d", v.name, i), wq[i].a, i);
      chk($sformatf("%s/data%0d", v.name, i), wq[i].d, v.w[i]);
    end
  endtask

  task automatic halt_core(input string tag);
    @(negedge clk);
    cpu_halt = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    chk({tag, "/halt_cpu_run"}, cpu_run, 0);
    chk({tag, "/halt_done"}, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nq;
    vec_t dv;
    vecs[0] = '{name:"two_word", n:2, w:'{32'h00810005, 32'h01C00000, 32'h0, 32'h0}, gap:0, exp_err:0};
    vecs[1] = '{name:"zero_len", n:0, w:'{32'h0, 32'h0, 32'h0, 32'h0}, gap:0, exp_err:0};
    vecs[2] = '{name:"oversize", n:5, w:'{32'h0, 32'h0, 32'h0, 32'h0}, gap:0, exp_err:1};
    vecs[3] = '{name:"gapped", n:3, w:'{32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h0}, gap:1, exp_err:0};
    vecs[4] = '{name:"full_depth", n:4, w:'{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4}, gap:0, exp_err:0};

    #2 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cpu_halt = 1'b1;
    repeat (2) @(negedge clk);
    cpu_halt = 1'b0;
    chk("halt_in_idle/done", done, 0);
    chk("halt_in_idle/cpu_run", cpu_run, 0);

    for (int k = 0; k < 5; k++) begin
      run_load(vecs[k]);
      if (!vecs[k].exp_err) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({vecs[k].name, "/start_in_run_busy"}, busy, 0);
        chk({vecs[k].name, "/start_in_run_cpu_run"}, cpu_run, 1);
        halt_core(vecs[k].name);
      end
    end

    dv = '{name:"reload", n:1, w:'{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, gap:0, exp_err:0};
    run_load(dv);
    halt_core("reload");

    @(negedge clk);
    wq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (vecs[0].w[i]) if (i < 1) ;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 1) ? 8'h02 : ((i == 3) ? 8'h81 : ((i == 5) ? 8'h05 : 8'h00));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midload/first_write_seen", mem_we, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midload_reset");
    nq = wq.size();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("midload/no_writes_after_reset", wq.size(), nq);
    chk("midload/busy_after_reset", busy, 0);
    chk("midload/in_ready_after_reset", in_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lc2k_program_loader.md
Name: lc2k_program_loader

Overview:
- Boot-time front end placed directly upstream of the LC2K CPU core.
- Receives a byte stream holding an assembled LC2K machine-code image and assembles it into 32-bit words.
- Writes each word into the unified instruction/data memory at consecutive addresses starting at 0.
- Holds the core stopped until the image is fully loaded, then raises cpu_run; returns to a stopped state when the core reports halt.

Parameters:
- MEM_DEPTH, 65536: number of 32-bit memory words; legal image length is 0..MEM_DEPTH.
- ADDR_WIDTH, 16: width of mem_addr; MEM_DEPTH must be ≤ 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a load (ignored while busy)
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  memory write strobe, one cycle per word
- mem_addr  output  ADDR_WIDTH  word address for the write
- mem_wdata  output  32  assembled word
- cpu_halt  input  1  core executed halt (level)
- cpu_run  output  1  core may execute; 0 holds the core
- busy  output  1  load in progress (states HDR0, HDR1, WORD)
- done  output  1  core has halted after a run
- error  output  1  header length exceeds MEM_DEPTH
- word_count  output  16  header length N, latched

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready, mem_we, cpu_run, busy, done and error are 0.
  - mem_addr, mem_wdata and word_count are 0.
  - The byte counter and word counter are 0.
- States: IDLE, HDR0, HDR1, WORD, RUN, DONE, ERR.
- Byte acceptance: a byte transfers on a rising edge with in_valid=1 and in_ready=1.
- in_ready is 1 exactly in HDR0, HDR1 and WORD; the loader never stalls within those states.
- IDLE/DONE/ERR:
  - start=1 → HDR0 on the next edge.
  - Clears done, error, and the byte and word counters.
- HDR0: accepted byte → word_count[15:8]; → HDR1.
- HDR1: accepted byte → word_count[7:0]. Then, using the full 16-bit N:
  - N > MEM_DEPTH → ERR; error=1.
  - N = 0 → RUN.
  - Otherwise → WORD.
- WORD:
  - Bytes arrive big-endian: the first byte is bits 31:24.
  - A 2-bit byte counter wraps 3→0.
  - On the 4th byte of a word:
    - The next cycle drives mem_we=1 for exactly one cycle.
    - mem_addr = word index (0, 1, …, N-1).
    - mem_wdata = the assembled word.
  - Bytes of the following word may be accepted in the same cycle mem_we is high.
  - After word N-1 is accepted → RUN.
  - cpu_run rises on the cycle after the final mem_we, never coincident with it.
- RUN:
  - cpu_run=1; in_ready=0; stream bytes are ignored.
  - cpu_halt=1 → DONE on the next edge; cpu_run=0 and done=1 from that edge.
- ERR: error=1, in_ready=0, cpu_run=0. No memory writes occur after the header.
- start while busy or in RUN: ignored.
- cpu_halt outside RUN: ignored.
- mem_we is never asserted outside WORD, except the single trailing write cycle.
- mem_addr is never ≥ N.
- Reset mid-load or mid-run: everything returns to reset values immediately. Partially written memory is not scrubbed. A new start is required.
- Arithmetic:
  - The word counter is ADDR_WIDTH+1 bits so that N = MEM_DEPTH = 2^ADDR_WIDTH is representable.
  - mem_addr is its low ADDR_WIDTH bits.

Test Plan:
- Load 2 words: start, then bytes 00 02 | 00 81 00 05 | 01 C0 00 00.
  - mem_we pulses twice: (addr 0, 0x00810005), then (addr 1, 0x01C00000).
  - cpu_run rises 1 cycle after the second write.
  - busy=0 and word_count=2.
- Zero-length image: header 00 00.
  - No mem_we.
  - cpu_run=1 on the edge after the second header byte.
- Oversize with MEM_DEPTH=4: header 00 05.
  - error=1; in_ready=0; no mem_we; cpu_run=0.
  - A subsequent start clears error and in_ready returns to 1.
- Gapped stream: in_valid toggled 1/0 every cycle for a 3-word image.
  - Writes 0..2 carry correct data.
  - Each mem_we lasts exactly 1 cycle; no duplicate writes.
- Halt/restart: in RUN, assert cpu_halt.
  - Next edge: cpu_run=0, done=1.
  - A start pulse during RUN is ignored.
  - A start pulse in DONE reloads the 1-word image 00 01 | DE AD BE EF: write (0, 0xDEADBEEF).
- Reset mid-load: drop rst_n after 6 of the 10 bytes.
  - All outputs are 0 asynchronously.
  - No further mem_we after rst_n rises until a new start.
